// File: rtl/sfp_link_pkg.sv
// Shared types and constants for the SFP link supervisor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sfp_link_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        WAIT  = 2'd1,
        UP    = 2'd2,
        FAULT = 2'd3
    } sup_state_t;

    localparam int STAT_W  = 16;
    localparam int RETRY_W = 8;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfp_sync_bits.sv
// Two-flop synchronizer for a bundle of independent asynchronous status bits.
// Latency: 2 cycles from input edge to o_sync.
// Backpressure: none; free-running, every bit sampled each cycle.
//
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, flops clear to 0
//   i_async  asynchronous input bits
//   o_sync   synchronised copy of i_async
module sfp_sync_bits #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/sfp_link_supervisor.sv
// Supervises N SFP PCS/PMA channels: link-up sync, user reset with bounded retries, fault latch, status LEDs.
// Latency: link_up_in edge -> sleds/FSM outputs in 3 cycles; all outputs registered.
// Backpressure: none; status inputs sampled every cycle, fault_clear is a one-cycle pulse honoured only in FAULT.
//
// Ports:
//   sysclk_100m       system clock (only clock)
//   sys_reset_n       asynchronous active-low reset
//   link_up_in        per-channel link status, asynchronous
//   chan_enable       channels taking part in supervision
//   fault_clear       pulse that leaves FAULT and restarts the reset sequence
//   user_reset_out    active-high reset to the PCS/PMA cores
//   sleds             per-link LEDs, heartbeat LED, fault LED
//   all_links_up      every enabled channel up and FSM in UP
//   supervisor_fault  retries exhausted
//   retry_count       resets reissued since the last UP
// Optional build macro SFP_LINK_SUPERVISOR_STATS_EN adds:
//   stats_clear       zeroes all link-drop counters (wins over a same-cycle increment)
//   link_drop_count   per-channel saturating 16-bit count of eff 1->0 transitions
module sfp_link_supervisor
    import sfp_link_pkg::*;
#(
    parameter int SFP_COUNT           = 2,
    parameter int LED_COUNT           = 4,
    parameter int LINK_TIMEOUT_CYCLES = 50_000_000,
    parameter int RESET_PULSE_CYCLES  = 16,
    parameter int MAX_RETRIES         = 7,
    parameter int BLINK_CYCLES        = 25_000_000
) (
    input  logic                 sysclk_100m,
    input  logic                 sys_reset_n,
    input  logic [SFP_COUNT-1:0] link_up_in,
    input  logic [SFP_COUNT-1:0] chan_enable,
    input  logic                 fault_clear,
    output logic                 user_reset_out,
    output logic [LED_COUNT-1:0] sleds,
    output logic                 all_links_up,
    output logic                 supervisor_fault,
    output logic [RETRY_W-1:0]   retry_count
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
    ,
    input  logic                        stats_clear,
    output logic [SFP_COUNT*STAT_W-1:0] link_drop_count
`endif
);

    localparam int TO_W = cnt_w(LINK_TIMEOUT_CYCLES);
    localparam int PU_W = cnt_w(RESET_PULSE_CYCLES);
    localparam int BL_W = cnt_w(BLINK_CYCLES);

    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(LINK_TIMEOUT_CYCLES - 1);
    localparam logic [PU_W-1:0]    PU_LAST   = PU_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [BL_W-1:0]    BL_LAST   = BL_W'(BLINK_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic [SFP_COUNT-1:0] w_link_s;
    logic [SFP_COUNT-1:0] w_eff;
    logic                 w_all_en_up;

    sup_state_t           r_state;
    sup_state_t           w_state_nxt;
    logic [PU_W-1:0]      r_pulse_cnt;
    logic [PU_W-1:0]      w_pulse_nxt;
    logic [TO_W-1:0]      r_to_cnt;
    logic [TO_W-1:0]      w_to_nxt;
    logic [RETRY_W-1:0]   r_retry;
    logic [RETRY_W-1:0]   w_retry_nxt;

    logic [BL_W-1:0]      r_blink_cnt;
    logic [BL_W-1:0]      w_blink_nxt;
    logic                 r_hb;
    logic                 w_hb_nxt;

    logic                 w_rst_nxt;
    logic                 w_up_nxt;
    logic                 w_fault_nxt;
    logic [LED_COUNT-1:0] w_sleds_nxt;

    logic                 r_user_reset;
    logic                 r_all_up;
    logic                 r_fault;
    logic [LED_COUNT-1:0] r_sleds;

    sfp_sync_bits #(
        .WIDTH (SFP_COUNT)
    ) u_link_sync (
        .i_clk   (sysclk_100m),
        .i_rst_n (sys_reset_n),
        .i_async (link_up_in),
        .o_sync  (w_link_s)
    );

    assign w_eff       = w_link_s & chan_enable;
    assign w_all_en_up = (chan_enable != '0) && (w_eff == chan_enable);

    // State register, including the counters owned by the FSM.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state     <= RESET;
            r_pulse_cnt <= '0;
            r_to_cnt    <= '0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_to_cnt    <= w_to_nxt;
            r_retry     <= w_retry_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = r_pulse_cnt;
        w_to_nxt    = r_to_cnt;
        w_retry_nxt = r_retry;
        case (r_state)
            RESET: begin
                if (r_pulse_cnt == PU_LAST) begin
                    w_state_nxt = WAIT;
                    w_pulse_nxt = '0;
                    w_to_nxt    = '0;
                end else begin
                    w_pulse_nxt = r_pulse_cnt + 1'b1;
                end
            end
            WAIT: begin
                // Link-up is checked before the timeout so a coincident
                // timeout never throws away a link that just came up.
                if (w_all_en_up) begin
                    w_state_nxt = UP;
                    w_retry_nxt = '0;
                    w_to_nxt    = '0;
                end else if (chan_enable == '0) begin
                    w_to_nxt = '0;
                end else if (r_to_cnt == TO_LAST) begin
                    w_to_nxt = '0;
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = FAULT;
                    end else begin
                        w_state_nxt = RESET;
                        w_pulse_nxt = '0;
                        w_retry_nxt = r_retry + 1'b1;
                    end
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            UP: begin
                // A dropped link only restarts the timeout; the reset is
                // reissued later if the link does not recover in time.
                if (!w_all_en_up) begin
                    w_state_nxt = WAIT;
                    w_to_nxt    = '0;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    w_state_nxt = RESET;
                    w_pulse_nxt = '0;
                    w_retry_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = RESET;
                w_pulse_nxt = '0;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line
    // up with the state register instead of trailing it by a cycle.
    always_comb begin
        w_rst_nxt   = (w_state_nxt == RESET);
        w_up_nxt    = (w_state_nxt == UP);
        w_fault_nxt = (w_state_nxt == FAULT);
    end

    // Heartbeat: free-running toggle, held dark while faulted.
    always_comb begin
        w_blink_nxt = r_blink_cnt;
        w_hb_nxt    = r_hb;
        if (w_fault_nxt) begin
            w_blink_nxt = '0;
            w_hb_nxt    = 1'b0;
        end else if (r_blink_cnt == BL_LAST) begin
            w_blink_nxt = '0;
            w_hb_nxt    = ~r_hb;
        end else begin
            w_blink_nxt = r_blink_cnt + 1'b1;
        end
    end

    // LED map; generate-if keeps out-of-range indices from ever elaborating
    // when LED_COUNT and SFP_COUNT differ.
    for (genvar g = 0; g < LED_COUNT; g++) begin : g_led
        if (g < SFP_COUNT) begin : g_link
            assign w_sleds_nxt[g] = w_eff[g];
        end else if (g == SFP_COUNT) begin : g_hb
            assign w_sleds_nxt[g] = w_hb_nxt;
        end else if (g == LED_COUNT - 1) begin : g_fault
            assign w_sleds_nxt[g] = w_fault_nxt;
        end else begin : g_off
            assign w_sleds_nxt[g] = 1'b0;
        end
    end

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_user_reset <= 1'b1;
            r_all_up     <= 1'b0;
            r_fault      <= 1'b0;
            r_sleds      <= '0;
            r_blink_cnt  <= '0;
            r_hb         <= 1'b0;
        end else begin
            r_user_reset <= w_rst_nxt;
            r_all_up     <= w_up_nxt;
            r_fault      <= w_fault_nxt;
            r_sleds      <= w_sleds_nxt;
            r_blink_cnt  <= w_blink_nxt;
            r_hb         <= w_hb_nxt;
        end
    end

    assign user_reset_out   = r_user_reset;
    assign all_links_up     = r_all_up;
    assign supervisor_fault = r_fault;
    assign sleds            = r_sleds;
    assign retry_count      = r_retry;

`ifdef SFP_LINK_SUPERVISOR_STATS_EN
    logic [SFP_COUNT-1:0] r_eff_prev;
    logic [STAT_W-1:0]    r_drop_cnt [SFP_COUNT];

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_eff_prev <= '0;
            for (int i = 0; i < SFP_COUNT; i++) begin
                r_drop_cnt[i] <= '0;
            end
        end else begin
            r_eff_prev <= w_eff;
            for (int i = 0; i < SFP_COUNT; i++) begin
                if (stats_clear) begin
                    r_drop_cnt[i] <= '0;
                end else if (r_eff_prev[i] && !w_eff[i] && (r_drop_cnt[i] != '1)) begin
                    r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < SFP_COUNT; g++) begin : g_stat
        assign link_drop_count[g*STAT_W +: STAT_W] = r_drop_cnt[g];
    end
`endif

endmodule

// File: tb/tb_sfp_link_supervisor.sv
module tb_sfp_link_supervisor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] link;
    logic [1:0] en;
    logic       fclr;
    logic       ureset;
    logic [3:0] sleds;
    logic       aup;
    logic       flt;
    logic [7:0] rcnt;
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
    logic        sclr;
    logic [31:0] drops;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expectations queued with the stimulus, observations queued
    // as the DUT produces them, drained in order at the end of each task.
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    sfp_link_supervisor #(
        .SFP_COUNT           (2),
        .LED_COUNT           (4),
        .LINK_TIMEOUT_CYCLES (100),
        .RESET_PULSE_CYCLES  (4),
        .MAX_RETRIES         (2),
        .BLINK_CYCLES        (8)
    ) dut (
        .sysclk_100m      (clk),
        .sys_reset_n      (rst_n),
        .link_up_in       (link),
        .chan_enable      (en),
        .fault_clear      (fclr),
        .user_reset_out   (ureset),
        .sleds            (sleds),
        .all_links_up     (aup),
        .supervisor_fault (flt),
        .retry_count      (rcnt)
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
        ,
        .stats_clear      (sclr),
        .link_drop_count  (drops)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_v(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    // Counts low samples before a reset pulse, then its high samples.
    task automatic wait_pulse(input int budget, output int gap, output int width, output int rc);
        gap = 0; width = 0; rc = -1;
        while (ureset !== 1'b1 && gap < budget) begin tick(1); gap++; end
        if (ureset !== 1'b1) begin gap = -1; width = -1; return; end
        rc = int'(rcnt);
        while (ureset === 1'b1 && width < budget) begin tick(1); width++; end
    endtask

    task automatic wait_up(input int budget, output int n);
        n = 0;
        while (aup !== 1'b1 && n < budget) begin tick(1); n++; end
        if (aup !== 1'b1) n = -1;
    endtask

    task automatic test_reset;
        int g, w, r;
        logic [31:0] e, o; string t;
        rst_n = 1'b0; link = 2'b00; en = 2'b11; fclr = 1'b0;
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
        sclr = 1'b0;
`endif
        tick(3);
        expect_v("rst_user_reset", 1); expect_v("rst_sleds", 0); expect_v("rst_all_up", 0);
        expect_v("rst_fault", 0); expect_v("rst_retry", 0);
        obs_q.push_back(32'(ureset)); obs_q.push_back(32'(sleds)); obs_q.push_back(32'(aup));
        obs_q.push_back(32'(flt)); obs_q.push_back(32'(rcnt));
        rst_n = 1'b1;
        expect_v("init_gap", 0); expect_v("init_width", 4); expect_v("init_retry", 0);
        wait_pulse(20, g, w, r);
        obs_q.push_back(32'(g)); obs_q.push_back(32'(w)); obs_q.push_back(32'(r));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_link_up;
        logic prev; int a, b;
        logic [31:0] e, o; string t;
        link = 2'b11;
        expect_v("up_before_sync", 0); expect_v("up_latency3", 1);
        expect_v("up_retry", 0); expect_v("up_sleds_links", 3);
        tick(2); obs_q.push_back(32'(aup));
        tick(1); obs_q.push_back(32'(aup)); obs_q.push_back(32'(rcnt)); obs_q.push_back(32'(sleds[1:0]));
        expect_v("heartbeat_period", 8);
        prev = sleds[2]; a = -1; b = -1;
        for (int i = 1; i <= 40 && b < 0; i++) begin
            tick(1);
            if (sleds[2] !== prev) begin
                if (a < 0) a = i; else b = i;
                prev = sleds[2];
            end
        end
        obs_q.push_back(32'(b - a));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_retry_fault;
        int g, w, r, n;
        logic [31:0] e, o; string t;
        link = 2'b00;
        expect_v("retry1_gap", 103); expect_v("retry1_width", 4); expect_v("retry1_count", 1);
        wait_pulse(300, g, w, r);
        obs_q.push_back(32'(g)); obs_q.push_back(32'(w)); obs_q.push_back(32'(r));
        expect_v("retry2_gap", 100); expect_v("retry2_width", 4); expect_v("retry2_count", 2);
        wait_pulse(300, g, w, r);
        obs_q.push_back(32'(g)); obs_q.push_back(32'(w)); obs_q.push_back(32'(r));
        expect_v("fault_delay", 100); expect_v("fault_user_reset", 0); expect_v("fault_led", 1);
        expect_v("fault_hb_led", 0); expect_v("fault_link_leds", 0); expect_v("fault_retry", 2);
        n = 0;
        while (flt !== 1'b1 && n < 300) begin tick(1); n++; end
        if (flt !== 1'b1) n = -1;
        obs_q.push_back(32'(n)); obs_q.push_back(32'(ureset)); obs_q.push_back(32'(sleds[3]));
        obs_q.push_back(32'(sleds[2])); obs_q.push_back(32'(sleds[1:0])); obs_q.push_back(32'(rcnt));
        expect_v("fault_hb_held", 0); expect_v("fault_held", 1);
        tick(20);
        obs_q.push_back(32'(sleds[2])); obs_q.push_back(32'(flt));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_fault_clear;
        int g, w, r, n, highs;
        logic [31:0] e, o; string t;
        link = 2'b11;
        tick(4);
        fclr = 1'b1; tick(1); fclr = 1'b0;
        expect_v("clr_gap", 0); expect_v("clr_width", 4); expect_v("clr_retry", 0); expect_v("clr_fault_off", 0);
        obs_q.push_back(32'(0));
        wait_pulse(20, g, w, r);
        obs_q.pop_back();
        obs_q.push_back(32'(g)); obs_q.push_back(32'(w)); obs_q.push_back(32'(r)); obs_q.push_back(32'(flt));
        expect_v("clr_up_latency", 1);
        wait_up(20, n);
        obs_q.push_back(32'(n));
        expect_v("clr_ignored_resets", 0); expect_v("clr_ignored_up", 1);
        fclr = 1'b1; highs = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1); fclr = 1'b0;
            if (ureset !== 1'b0) highs++;
        end
        obs_q.push_back(32'(highs)); obs_q.push_back(32'(aup));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_chan_enable;
        int highs;
        logic [31:0] e, o; string t;
        en = 2'b01; link = 2'b01;
        expect_v("en01_up", 1); expect_v("en01_leds", 1); expect_v("en01_no_reset", 0);
        tick(3);
        obs_q.push_back(32'(aup)); obs_q.push_back(32'(sleds[1:0])); obs_q.push_back(32'(ureset));
        en = 2'b00;
        expect_v("en00_left_up", 0);
        tick(1); obs_q.push_back(32'(aup));
        expect_v("en00_resets", 0); expect_v("en00_retry", 0); expect_v("en00_up", 0); expect_v("en00_leds", 0);
        highs = 0;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (ureset !== 1'b0) highs++;
        end
        obs_q.push_back(32'(highs)); obs_q.push_back(32'(rcnt));
        obs_q.push_back(32'(aup)); obs_q.push_back(32'(sleds[1:0]));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_link_drop;
        int n, first_down, highs;
        logic led1;
        logic [31:0] e, o; string t;
        en = 2'b11; link = 2'b11;
        expect_v("drop_pre_up", 3);
        wait_up(20, n); obs_q.push_back(32'(n));
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
        sclr = 1'b1; tick(1); sclr = 1'b0;
`endif
        link = 2'b01;
        expect_v("drop_down_latency", 3); expect_v("drop_no_reset", 0); expect_v("drop_led1", 0);
        first_down = -1; highs = 0; led1 = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (aup === 1'b0 && first_down < 0) first_down = i;
            if (ureset !== 1'b0) highs++;
            if (i == 5) led1 = sleds[1];
        end
        obs_q.push_back(32'(first_down)); obs_q.push_back(32'(highs)); obs_q.push_back(32'(led1));
        link = 2'b11;
        expect_v("drop_recover", 3);
        wait_up(20, n); obs_q.push_back(32'(n));
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
        expect_v("stats_ch1", 1); expect_v("stats_ch0", 0);
        obs_q.push_back(32'(drops[31:16])); obs_q.push_back(32'(drops[15:0]));
        sclr = 1'b1; tick(1); sclr = 1'b0;
        expect_v("stats_cleared", 0);
        obs_q.push_back(drops);
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    task automatic test_async_reset;
        int n, g, w, r, highs;
        logic [31:0] e, o; string t;
        link = 2'b00;
        expect_v("ar_rise_gap", 103); expect_v("ar_retry_before", 1);
        n = 0;
        while (ureset !== 1'b1 && n < 300) begin tick(1); n++; end
        if (ureset !== 1'b1) n = -1;
        obs_q.push_back(32'(n)); obs_q.push_back(32'(rcnt));
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        expect_v("ar_user_reset", 1); expect_v("ar_sleds", 0); expect_v("ar_all_up", 0);
        expect_v("ar_fault", 0); expect_v("ar_retry", 0);
        obs_q.push_back(32'(ureset)); obs_q.push_back(32'(sleds)); obs_q.push_back(32'(aup));
        obs_q.push_back(32'(flt)); obs_q.push_back(32'(rcnt));
`ifdef SFP_LINK_SUPERVISOR_STATS_EN
        expect_v("ar_stats", 0); obs_q.push_back(drops);
`endif
        tick(1);
        rst_n = 1'b1;
        expect_v("ar_gap", 0); expect_v("ar_width", 4); expect_v("ar_pulse_retry", 0);
        wait_pulse(20, g, w, r);
        obs_q.push_back(32'(g)); obs_q.push_back(32'(w)); obs_q.push_back(32'(r));
        // Links arrive at the FSM on the very cycle the timeout expires.
        expect_v("edge_no_reset", 0); expect_v("edge_up_wins", 1); expect_v("edge_retry", 0);
        highs = 0;
        for (int i = 0; i < 97; i++) begin tick(1); if (ureset !== 1'b0) highs++; end
        link = 2'b11;
        for (int i = 0; i < 3; i++) begin tick(1); if (ureset !== 1'b0) highs++; end
        obs_q.push_back(32'(highs)); obs_q.push_back(32'(aup)); obs_q.push_back(32'(rcnt));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); n_checks++;
            if (o !== e) begin n_errors++; $display("FAIL %s: got %0d expected %0d", t, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_retry_fault();
        test_fault_clear();
        test_chan_enable();
        test_link_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
